// File: rtl/tcu_pkg.sv
// tcu_pkg: shared encodings and default constants for the timing control unit.
package tcu_pkg;

  // Decoder command encodings carried on i_cmd
  localparam logic [1:0] TCU_CMD_INC     = 2'b00;
  localparam logic [1:0] TCU_CMD_LOAD    = 2'b01;
  localparam logic [1:0] TCU_CMD_RESTART = 2'b10;
  localparam logic [1:0] TCU_CMD_JAM     = 2'b11;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    TCU_ST_BOOT = 2'd0,
    TCU_ST_RUN  = 2'd1,
    TCU_ST_JAM  = 2'd2
  } tcu_state_e;

  // Default geometry for the 6502 core
  localparam int TCU_DEF_T_WIDTH     = 4;
  localparam int TCU_DEF_MAX_T       = 7;
  localparam int TCU_DEF_SYNC_T      = 1;
  localparam int TCU_DEF_BOOT_CYCLES = 7;
  localparam int TCU_DEF_CNT_WIDTH   = 32;

endpackage

// File: rtl/tcu_cycle_counter.sv
// tcu_cycle_counter: free-running count of enabled falling edges, wraps
// modulo 2^CNT_WIDTH. Cleared asynchronously by i_reset.
module tcu_cycle_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_en,
  output logic [CNT_WIDTH-1:0] o_count
);

  logic [CNT_WIDTH-1:0] r_count;

  // Count every falling edge on which the sequencer made real progress
  always_ff @(negedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/tcu_sequencer.sv
// tcu_sequencer: per-instruction T-cycle sequencer with boot sequence,
// RDY stalling and illegal-opcode jam. All state moves on the falling edge
// of i_clk; i_reset is asynchronous, active-high.
// Optional build macro TCU_CYCLE_COUNTER_EN adds the unstalled cycle
// counter; without it o_cycle_count is tied to zero.
module tcu_sequencer
  import tcu_pkg::*;
#(
  parameter int T_WIDTH     = TCU_DEF_T_WIDTH,
  parameter int MAX_T       = TCU_DEF_MAX_T,
  parameter int SYNC_T      = TCU_DEF_SYNC_T,
  parameter int BOOT_CYCLES = TCU_DEF_BOOT_CYCLES,
  parameter int CNT_WIDTH   = TCU_DEF_CNT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rdy,
  input  logic                 i_rw,
  input  logic [1:0]           i_cmd,
  input  logic [T_WIDTH-1:0]   i_tcu_next,
  output logic [T_WIDTH-1:0]   o_tcu,
  output logic                 o_sync,
  output logic                 o_booting,
  output logic                 o_stalled,
  output logic                 o_jammed,
  output logic                 o_overflow,
  output logic [CNT_WIDTH-1:0] o_cycle_count
);

  localparam logic [T_WIDTH-1:0] MAX_T_L     = T_WIDTH'(MAX_T);
  localparam logic [T_WIDTH-1:0] SYNC_T_L    = T_WIDTH'(SYNC_T);
  localparam logic [T_WIDTH-1:0] BOOT_LAST_L = T_WIDTH'(BOOT_CYCLES - 1);

  tcu_state_e         r_state;
  tcu_state_e         w_state_next;
  logic [T_WIDTH-1:0] r_tcu;
  logic [T_WIDTH-1:0] w_tcu_next;
  logic               r_overflow;
  logic               w_overflow_next;
  logic               w_stall;

  // RDY only stretches read cycles; writes always complete
  assign w_stall = ~i_rdy & i_rw;

  // State registers; reset parks T at all-ones so the first boot edge reads 0
  always_ff @(negedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= TCU_ST_BOOT;
      r_tcu      <= '1;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_tcu      <= w_tcu_next;
      r_overflow <= w_overflow_next;
    end
  end

  // Next-state and next-T decisions; defaults hold everything
  always_comb begin
    w_state_next    = r_state;
    w_tcu_next      = r_tcu;
    w_overflow_next = r_overflow;
    case (r_state)
      TCU_ST_BOOT: begin
        // Decoder commands are meaningless until the boot walk completes
        if (!w_stall) begin
          if (r_tcu == BOOT_LAST_L) begin
            w_tcu_next   = '0;
            w_state_next = TCU_ST_RUN;
          end else begin
            w_tcu_next = r_tcu + T_WIDTH'(1);
          end
        end
      end
      TCU_ST_RUN: begin
        if (i_cmd == TCU_CMD_JAM) begin
          // Jam wins over a stall so a halted bus cannot mask the lockup
          w_state_next = TCU_ST_JAM;
        end else if (!w_stall) begin
          // A stalled command is dropped; the decoder re-presents it
          case (i_cmd)
            TCU_CMD_INC: begin
              if (r_tcu == MAX_T_L) begin
                w_tcu_next      = '0;
                w_overflow_next = 1'b1;
              end else begin
                w_tcu_next = r_tcu + T_WIDTH'(1);
              end
            end
            TCU_CMD_LOAD: begin
              if (i_tcu_next > MAX_T_L) begin
                w_tcu_next      = '0;
                w_overflow_next = 1'b1;
              end else begin
                w_tcu_next = i_tcu_next;
              end
            end
            TCU_CMD_RESTART: begin
              w_tcu_next = '0;
            end
            default: begin
              w_tcu_next = r_tcu;
            end
          endcase
        end
      end
      TCU_ST_JAM: begin
        // Terminal: only reset leaves this state
        w_state_next = TCU_ST_JAM;
      end
      default: begin
        // Unreachable encoding: fail safe into the lockup state
        w_state_next = TCU_ST_JAM;
      end
    endcase
  end

  assign o_tcu      = r_tcu;
  assign o_overflow = r_overflow;
  assign o_booting  = (r_state == TCU_ST_BOOT);
  assign o_jammed   = (r_state == TCU_ST_JAM);
  assign o_stalled  = w_stall & (r_state != TCU_ST_JAM);
  assign o_sync     = (r_state == TCU_ST_RUN) && (r_tcu == SYNC_T_L);

`ifdef TCU_CYCLE_COUNTER_EN
  logic w_count_en;

  // Count progress edges in BOOT and RUN; a jammed core makes no progress
  assign w_count_en = ~w_stall & (r_state != TCU_ST_JAM);

  tcu_cycle_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cycle_counter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (w_count_en),
    .o_count (o_cycle_count)
  );
`else
  assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_tcu_sequencer.sv
// tb_tcu_sequencer: directed vectors for tcu_sequencer with hand-computed
// expectations. DUT updates on the falling edge; outputs are sampled 1 ns
// after it.
module tb_tcu_sequencer;

  logic        i_clk;
  logic        i_reset;
  logic        i_rdy;
  logic        i_rw;
  logic [1:0]  i_cmd;
  logic [3:0]  i_tcu_next;
  logic [3:0]  o_tcu;
  logic        o_sync;
  logic        o_booting;
  logic        o_stalled;
  logic        o_jammed;
  logic        o_overflow;
  logic [31:0] o_cycle_count;

  int n_vec = 0;
  int n_mis = 0;

  localparam logic [1:0] C_INC     = 2'b00;
  localparam logic [1:0] C_LOAD    = 2'b01;
  localparam logic [1:0] C_RESTART = 2'b10;
  localparam logic [1:0] C_JAM     = 2'b11;

  tcu_sequencer dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_rdy         (i_rdy),
    .i_rw          (i_rw),
    .i_cmd         (i_cmd),
    .i_tcu_next    (i_tcu_next),
    .o_tcu         (o_tcu),
    .o_sync        (o_sync),
    .o_booting     (o_booting),
    .o_stalled     (o_stalled),
    .o_jammed      (o_jammed),
    .o_overflow    (o_overflow),
    .o_cycle_count (o_cycle_count)
  );

  initial begin
    i_clk = 1'b1;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, required %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one falling edge and settle
  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  // Expected counter value depends on whether the counter is built
  function automatic logic [31:0] cexp(input int n);
`ifdef TCU_CYCLE_COUNTER_EN
    return 32'(n);
`else
    return 32'(n & 0);
`endif
  endfunction

  task automatic apply(input logic [1:0] cmd, input logic [3:0] nxt);
    i_cmd      = cmd;
    i_tcu_next = nxt;
    step();
  endtask

  initial begin
    i_reset    = 1'b1;
    i_rdy      = 1'b1;
    i_rw       = 1'b1;
    i_cmd      = C_JAM;
    i_tcu_next = 4'd0;
    #3;
    chk("rst_tcu", 32'(o_tcu), 32'hF);
    chk("rst_booting", 32'(o_booting), 32'd1);
    chk("rst_overflow", 32'(o_overflow), 32'd0);
    chk("rst_jammed", 32'(o_jammed), 32'd0);
    chk("rst_sync", 32'(o_sync), 32'd0);
    chk("rst_count", o_cycle_count, 32'd0);
    i_reset = 1'b0;

    // Boot with JAM held: T walks 0..6 then lands on 0 in RUN
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("boot%0d_tcu", i), 32'(o_tcu), (i == 7) ? 32'd0 : 32'(i));
      chk($sformatf("boot%0d_booting", i), 32'(o_booting), (i == 7) ? 32'd0 : 32'd1);
      chk($sformatf("boot%0d_sync", i), 32'(o_sync), 32'd0);
    end
    chk("boot_jammed", 32'(o_jammed), 32'd0);
    chk("boot_count", o_cycle_count, cexp(8));

    // Normal instruction with a read stall at T=2
    apply(C_INC, 4'd0);
    chk("run_t1", 32'(o_tcu), 32'd1);
    chk("run_t1_sync", 32'(o_sync), 32'd1);
    apply(C_INC, 4'd0);
    chk("run_t2", 32'(o_tcu), 32'd2);
    chk("run_t2_sync", 32'(o_sync), 32'd0);
    i_rdy = 1'b0;
    i_rw  = 1'b1;
    #1;
    chk("stall_flag_read", 32'(o_stalled), 32'd1);
    for (int i = 0; i < 3; i++) begin
      apply(C_INC, 4'd0);
      chk($sformatf("stall%0d_tcu", i), 32'(o_tcu), 32'd2);
      chk($sformatf("stall%0d_flag", i), 32'(o_stalled), 32'd1);
    end
    chk("stall_count", o_cycle_count, cexp(10));
    i_rw = 1'b0;
    #1;
    chk("stall_flag_write", 32'(o_stalled), 32'd0);
    apply(C_INC, 4'd0);
    chk("write_t3", 32'(o_tcu), 32'd3);
    i_rdy = 1'b1;
    i_rw  = 1'b1;
    apply(C_LOAD, 4'd0);
    chk("load0_tcu", 32'(o_tcu), 32'd0);
    chk("load0_ovf", 32'(o_overflow), 32'd0);
    apply(C_INC, 4'd0);
    chk("run2_t1", 32'(o_tcu), 32'd1);
    chk("count_13", o_cycle_count, cexp(13));

    // Overflow by INC past MAX_T, then sticky
    apply(C_LOAD, 4'd7);
    chk("load7_tcu", 32'(o_tcu), 32'd7);
    chk("load7_ovf", 32'(o_overflow), 32'd0);
    apply(C_INC, 4'd0);
    chk("incwrap_tcu", 32'(o_tcu), 32'd0);
    chk("incwrap_ovf", 32'(o_overflow), 32'd1);
    apply(C_INC, 4'd0);
    chk("sticky_tcu", 32'(o_tcu), 32'd1);
    chk("sticky_ovf", 32'(o_overflow), 32'd1);
    chk("sticky_booting", 32'(o_booting), 32'd0);
    apply(C_RESTART, 4'd5);
    chk("restart_tcu", 32'(o_tcu), 32'd0);
    chk("count_17", o_cycle_count, cexp(17));

    // Fresh reset; boot with an initial stall
    i_reset = 1'b1;
    #1;
    chk("rst2_ovf", 32'(o_overflow), 32'd0);
    chk("rst2_tcu", 32'(o_tcu), 32'hF);
    i_reset = 1'b0;
    i_rdy   = 1'b0;
    i_rw    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply(C_INC, 4'd0);
      chk($sformatf("bootstall%0d_tcu", i), 32'(o_tcu), 32'hF);
      chk($sformatf("bootstall%0d_flag", i), 32'(o_stalled), 32'd1);
    end
    i_rdy = 1'b1;
    for (int i = 0; i < 8; i++) apply(C_INC, 4'd0);
    chk("boot2_tcu", 32'(o_tcu), 32'd0);
    chk("boot2_booting", 32'(o_booting), 32'd0);
    chk("boot2_count", o_cycle_count, cexp(8));

    // Overflow by illegal LOAD
    apply(C_LOAD, 4'd9);
    chk("load9_tcu", 32'(o_tcu), 32'd0);
    chk("load9_ovf", 32'(o_overflow), 32'd1);

    // Jam at T=3 while stalled, then frozen under any command
    apply(C_LOAD, 4'd3);
    chk("prejam_tcu", 32'(o_tcu), 32'd3);
    i_rdy = 1'b0;
    i_rw  = 1'b1;
    apply(C_JAM, 4'd0);
    chk("jam_flag", 32'(o_jammed), 32'd1);
    chk("jam_tcu", 32'(o_tcu), 32'd3);
    chk("jam_stalled", 32'(o_stalled), 32'd0);
    for (int i = 0; i < 10; i++) begin
      i_rdy = 1'(i & 1);
      i_rw  = 1'(~i & 1);
      apply(2'(i), 4'd2);
      chk($sformatf("jam%0d_tcu", i), 32'(o_tcu), 32'd3);
      chk($sformatf("jam%0d_flag", i), 32'(o_jammed), 32'd1);
      chk($sformatf("jam%0d_sync", i), 32'(o_sync), 32'd0);
    end
    chk("jam_ovf_kept", 32'(o_overflow), 32'd1);
    chk("jam_count", o_cycle_count, cexp(10));

    // Asynchronous reset between edges leaves JAM immediately
    #2;
    i_reset = 1'b1;
    #1;
    chk("arst_tcu", 32'(o_tcu), 32'hF);
    chk("arst_jammed", 32'(o_jammed), 32'd0);
    chk("arst_booting", 32'(o_booting), 32'd1);
    chk("arst_ovf", 32'(o_overflow), 32'd0);
    chk("arst_count", o_cycle_count, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
